// File: rtl/cpu_io_port.sv
// CPU I/O port: buffered output FIFO, one-entry input holding register, run/stop control.
// Optional sticky drop flags on io_err when CPU_IO_ERR_FLAGS_EN is defined.
module cpu_io_port #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  cpu_out_we,
  input  logic [DATA_WIDTH-1:0] cpu_out_data,
  output logic                  cpu_out_stall,
  input  logic                  cpu_in_re,
  output logic [DATA_WIDTH-1:0] cpu_in_data,
  output logic                  cpu_in_valid,
  input  logic                  cpu_halt,
  output logic [DATA_WIDTH-1:0] Output_Data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [DATA_WIDTH-1:0] Input_Data,
  input  logic                  in_strobe,
  output logic                  in_ack,
  input  logic                  Start,
  input  logic                  Stop,
`ifdef CPU_IO_ERR_FLAGS_EN
  output logic [1:0]            io_err,
`endif
  output logic                  Run
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_HALTED,
    S_RUNNING,
    S_DRAINING
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [OUT_DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_in_data;
  logic                  r_in_valid;
  logic                  r_in_ack;
  logic                  r_run;
  state_t                r_state;
  state_t                w_state_nx;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_full;
  logic                  w_cap;
  logic [AW-1:0]         w_rptr_nx;
  logic [CW-1:0]         w_remain;

  assign out_valid     = (r_count != '0);
  assign w_full        = (r_count == CW'(OUT_DEPTH));
  assign w_pop         = out_valid & out_ready;
  assign cpu_out_stall = w_full & ~w_pop;
  assign w_push        = cpu_out_we & ~cpu_out_stall;
  assign w_rptr_nx     = w_pop ? r_rptr + AW'(1) : r_rptr;
  assign w_remain      = r_count - CW'(w_pop);
  assign w_cap         = in_strobe & (~r_in_valid | cpu_in_re);

  assign Output_Data   = r_head;
  assign cpu_in_data   = r_in_data;
  assign cpu_in_valid  = r_in_valid;
  assign in_ack        = r_in_ack;
  assign Run           = r_run;

  always_ff @(posedge Clock) begin
    if (w_push) r_mem[r_wptr] <= cpu_out_data;
  end

  // Head is re-registered every cycle; an empty FIFO bypasses the incoming word.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      r_rptr  <= w_rptr_nx;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_remain != '0) r_head <= r_mem[w_rptr_nx];
      else if (w_push)    r_head <= cpu_out_data;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_in_data  <= '0;
      r_in_valid <= 1'b0;
      r_in_ack   <= 1'b0;
    end else begin
      r_in_ack <= w_cap;
      if (w_cap) begin
        r_in_data  <= Input_Data;
        r_in_valid <= 1'b1;
      end else if (cpu_in_re) begin
        r_in_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_HALTED:   if (Start & ~Stop) w_state_nx = S_RUNNING;
      S_RUNNING:  if (Stop | cpu_halt) w_state_nx = S_DRAINING;
      S_DRAINING: if ((r_count == '0) & ~w_push) w_state_nx = S_HALTED;
      default:    w_state_nx = S_HALTED;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_HALTED;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_run   <= (w_state_nx == S_RUNNING);
    end
  end

`ifdef CPU_IO_ERR_FLAGS_EN
  logic [1:0] r_err;
  logic [1:0] w_err_set;
  logic       w_go;

  assign w_err_set = {in_strobe & r_in_valid & ~cpu_in_re,
                      cpu_out_we & cpu_out_stall};
  assign w_go      = (r_state == S_HALTED) & (w_state_nx == S_RUNNING);
  assign io_err    = r_err;

  always_ff @(posedge Clock) begin
    if (Reset) r_err <= 2'b00;
    else       r_err <= (w_go ? 2'b00 : r_err) | w_err_set;
  end
`endif

endmodule

// File: doc/cpu_io_port.md
Name: cpu_io_port

Overview:
- Device-side I/O and run-control unit that sits between the CPU core's in/out instruction datapath and the external world.
- It presents Output_Data, Run, Input_Data and Stop to the external side, the same interface a bench or board drives.
- Output writes from the CPU are buffered in a small FIFO and handed out with a valid/ready handshake.
- Input words are captured into a one-entry holding register.
- A run/stop FSM gates CPU execution and drains pending output before halting.

Parameters:
- DATA_WIDTH, 32, width of all data words.
- OUT_DEPTH, 4, output FIFO entries; power of two, at least 2.

Ports:
- Clock  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- cpu_out_we  in  1  CPU out-instruction write strobe.
- cpu_out_data  in  DATA_WIDTH  word to send.
- cpu_out_stall  out  1  write would be refused this cycle.
- cpu_in_re  in  1  CPU in-instruction read/consume strobe.
- cpu_in_data  out  DATA_WIDTH  held input word.
- cpu_in_valid  out  1  holding register contains an unread word.
- cpu_halt  in  1  CPU executed halt instruction (1-cycle pulse).
- Output_Data  out  DATA_WIDTH  FIFO head word.
- out_valid  out  1  Output_Data is valid.
- out_ready  in  1  external consumer accepts the word.
- Input_Data  in  DATA_WIDTH  external input word.
- in_strobe  in  1  Input_Data is valid this cycle.
- in_ack  out  1  pulse: previous-cycle strobe was captured.
- Start  in  1  begin execution (pulse).
- Stop  in  1  external stop request (level or pulse).
- Run  out  1  CPU may execute.

Behaviour:
- Reset (sync, any state):
  - FIFO empty, so out_valid=0 and Output_Data=0.
  - cpu_in_valid=0, cpu_in_data=0, in_ack=0.
  - FSM enters HALTED, Run=0.
- Output FIFO:
  - pop = out_valid & out_ready.
  - push = cpu_out_we & (count<OUT_DEPTH | pop).
  - cpu_out_stall = (count==OUT_DEPTH) & ~pop, combinational.
  - A push and a pop in the same cycle leave count unchanged, including when full.
  - A push while stalled is dropped.
  - Output_Data is the head word, registered from FIFO storage. Head advances the cycle after a pop.
  - First-word latency is 1 cycle: a write at edge N gives out_valid=1 after edge N.
  - Pointers wrap modulo OUT_DEPTH; count runs 0..OUT_DEPTH.
  - Output_Data holds its last value when the FIFO is empty (don't-care for checking, but stable).
- Input holding register:
  - If in_strobe and (~cpu_in_valid | cpu_in_re): capture Input_Data, set cpu_in_valid=1, and pulse in_ack=1 for the next cycle.
  - If cpu_in_re and ~in_strobe: cpu_in_valid goes to 0 next cycle; cpu_in_data is held.
  - A strobe while the register is full and no read: word dropped, no ack.
  - cpu_in_re while empty: no effect.
- Run FSM (Run is registered):
  - HALTED, Run=0:
    - Start & ~Stop goes to RUNNING.
    - Start & Stop together: stay HALTED.
  - RUNNING, Run=1:
    - Stop | cpu_halt goes to DRAINING; Run=0 from the next cycle.
    - Start is ignored.
  - DRAINING, Run=0:
    - When the FIFO is empty (count==0 and no push this cycle), go to HALTED.
    - Start is ignored.
    - CPU writes are still accepted and extend the drain.
  - cpu_halt outside RUNNING is ignored.
- I/O paths operate in all FSM states; Run gates only the CPU.

Optional Feature:
- Macro: CPU_IO_ERR_FLAGS_EN.
- Defined:
  - Adds output io_err[1:0], reset to 0.
  - bit0 is sticky, set when cpu_out_we is asserted while cpu_out_stall=1 (word dropped).
  - bit1 is sticky, set when in_strobe hits a full register with no cpu_in_re (word dropped).
  - Both bits clear on Reset or on a HALTED-to-RUNNING transition.
- Not defined:
  - Port io_err is absent.
  - Drops are silent; all other behaviour is identical.

Test Plan:
- Reset, Start pulse, then cpu_out_we with 0x11,0x22,0x33,0x44 and out_ready=0:
  - out_valid=1 one cycle after the first write.
  - cpu_out_stall=1 after the 4th.
  - A 5th write of 0x55 is dropped (io_err[0]=1 if enabled).
  - Raising out_ready yields 0x11,0x22,0x33,0x44 on consecutive cycles.
- Full FIFO with out_ready=1 and a simultaneous write of 0xAA:
  - Accepted, cpu_out_stall=0, count stays 4.
  - 0xAA emerges 4th after the current head.
- in_strobe with Input_Data=0xDEAD_BEEF:
  - cpu_in_valid=1, cpu_in_data=0xDEADBEEF, in_ack pulses 1 cycle.
  - A second strobe 0x1234 without a read is dropped: no ack, data unchanged.
  - The same strobe with cpu_in_re=1 captures 0x1234.
- RUNNING with 2 words queued and out_ready=0, assert Stop:
  - Run=0 next cycle, FSM in DRAINING.
  - After out_ready=1 pops both words, HALTED one cycle later.
  - Start during DRAINING is ignored.
- cpu_halt pulse in RUNNING with the FIFO empty: Run drops and the FSM reaches HALTED within 2 cycles. Start & Stop together in HALTED: Run stays 0.
- Reset asserted mid-DRAINING with 3 words queued: next cycle out_valid=0, Run=0, cpu_in_valid=0, HALTED (io_err=0 if enabled).
